// File: rtl/fdiv_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fdiv_pkg : shared types and per-format constants for the SRT divider     |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
package fdiv_pkg;

  typedef enum logic [1:0] {
    FMT_F16 = 2'd0,
    FMT_F32 = 2'd1,
    FMT_F64 = 2'd2
  } fmt_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_ITER = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam int unsigned ITER_F16 = 4;
  localparam int unsigned ITER_F32 = 7;
  localparam int unsigned ITER_F64 = 14;

  // Bit k set means k quotient LSBs beyond the target precision are dropped.
  localparam logic [3:0] DISC_SPECIAL = 4'b0001;
  localparam logic [3:0] DISC_F64     = 4'b0010;
  localparam logic [3:0] DISC_F32     = 4'b0100;
  localparam logic [3:0] DISC_F16     = 4'b1000;

  function automatic int unsigned iter_num(input fmt_e fmt);
    case (fmt)
      FMT_F16: return ITER_F16;
      FMT_F32: return ITER_F32;
      default: return ITER_F64;
    endcase
  endfunction

  function automatic logic [3:0] discard_one_hot(input fmt_e fmt);
    case (fmt)
      FMT_F16: return DISC_F16;
      FMT_F32: return DISC_F32;
      default: return DISC_F64;
    endcase
  endfunction

  // The reserved encoding runs as F64.
  function automatic fmt_e fmt_decode(input logic [1:0] raw);
    case (raw)
      2'd0:    return FMT_F16;
      2'd1:    return FMT_F32;
      default: return FMT_F64;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/fdiv_iter_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fdiv_iter_ctrl : IDLE/PRE/ITER/DONE sequencer for the radix-4 SRT divider |
// | Revision       : 1.0                                                     |
// +--------------------------------------------------------------------------+
module fdiv_iter_ctrl
  import fdiv_pkg::*;
#(
  parameter int unsigned CNT_W    = 6,
  parameter int unsigned F64_ITER = ITER_F64,
  parameter int unsigned F32_ITER = ITER_F32,
  parameter int unsigned F16_ITER = ITER_F16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid_i,
  output logic             start_ready_o,
  input  logic [1:0]       fmt_i,
  input  logic             special_i,
  input  logic             kill_i,
  output logic             iter_start_o,
  output logic             iter_vld_o,
  output logic             iter_end_o,
  output logic [CNT_W-1:0] iter_counter_o,
  output logic [CNT_W-1:0] quot_bits_calculated_o,
  output logic [3:0]       quot_discard_num_one_hot_o,
  output logic             done_valid_o,
  input  logic             done_ready_i,
  output logic             done_special_o
);

  state_e           state_q, state_d;
  fmt_e             fmt_q, fmt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       disc_q, disc_d;
  logic             special_q, special_d;

  logic [CNT_W-1:0] n_iter;
  logic             last_iter;

  always_comb begin
    n_iter = CNT_W'(F64_ITER);
    case (fmt_q)
      FMT_F16: n_iter = CNT_W'(F16_ITER);
      FMT_F32: n_iter = CNT_W'(F32_ITER);
      default: n_iter = CNT_W'(F64_ITER);
    endcase
  end

  assign last_iter = (state_q == ST_ITER) && (cnt_q == (n_iter - CNT_W'(1)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      fmt_q     <= FMT_F64;
      cnt_q     <= '0;
      disc_q    <= DISC_SPECIAL;
      special_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      fmt_q     <= fmt_d;
      cnt_q     <= cnt_d;
      disc_q    <= disc_d;
      special_q <= special_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    fmt_d     = fmt_q;
    cnt_d     = cnt_q;
    disc_d    = disc_q;
    special_d = special_q;
    if (kill_i) begin
      state_d   = ST_IDLE;
      cnt_d     = '0;
      special_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cnt_d = '0;
          if (start_valid_i) begin
            if (special_i) begin
              state_d   = ST_DONE;
              special_d = 1'b1;
              disc_d    = DISC_SPECIAL;
            end else begin
              state_d = ST_PRE;
              fmt_d   = fmt_decode(fmt_i);
            end
          end
        end
        ST_PRE: begin
          state_d = ST_ITER;
          cnt_d   = '0;
        end
        ST_ITER: begin
          if (last_iter) begin
            state_d = ST_DONE;
            cnt_d   = '0;
            disc_d  = discard_one_hot(fmt_q);
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_DONE: begin
          if (done_ready_i) begin
            state_d   = ST_IDLE;
            special_d = 1'b0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // The discard code is shown live on the last iteration, then from the register in DONE.
  always_comb begin
    start_ready_o              = (state_q == ST_IDLE);
    iter_start_o               = (state_q == ST_PRE);
    iter_vld_o                 = (state_q == ST_ITER);
    iter_end_o                 = last_iter;
    iter_counter_o             = cnt_q;
    quot_bits_calculated_o     = '0;
    quot_discard_num_one_hot_o = 4'b0000;
    done_valid_o               = (state_q == ST_DONE);
    done_special_o             = (state_q == ST_DONE) && special_q;
    if (state_q == ST_ITER) begin
      quot_bits_calculated_o = {cnt_q[CNT_W-3:0], 2'b11};
    end
    if (last_iter) begin
      quot_discard_num_one_hot_o = discard_one_hot(fmt_q);
    end else if (state_q == ST_DONE) begin
      quot_discard_num_one_hot_o = disc_q;
    end
  end

  a_cnt_in_range: assert property (@(posedge clk) disable iff (rst)
    (state_q == ST_ITER) |-> (cnt_q < n_iter));

endmodule
`default_nettype wire

// File: doc/fdiv_iter_ctrl.md
Name: fdiv_iter_ctrl

Overview:
- Iteration controller for the scalar F16/F32/F64 radix-4 SRT divider (two radix-4 stages per cycle, 4 quotient bits per iteration).
- Sits directly upstream of the SRT datapath and the SRT-to-restoring checking logic.
- Accepts an operation, then sequences pre-process, iteration and post-process.
- Generates iter_start/iter_vld/iter_end, the iteration counter, the count of quotient bits calculated, and the one-hot quotient-discard count that the downstream stages consume.

Parameters:
- CNT_W, 6, width of the iteration counter and of the quotient-bit count.
- F64_ITER, 14, iterations for F64 (55 bits calculated, 1 discarded).
- F32_ITER, 7, iterations for F32 (27 bits calculated, 2 discarded).
- F16_ITER, 4, iterations for F16 (15 bits calculated, 3 discarded).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- start_valid_i  in  1  new operation offered.
- start_ready_o  out  1  controller can accept an operation (high only in IDLE).
- fmt_i  in  2  format: 0=F16, 1=F32, 2=F64, 3=reserved (treated as F64).
- special_i  in  1  NaN/Inf/zero/div-by-zero operand; no iteration required.
- kill_i  in  1  flush the current operation.
- iter_start_o  out  1  one-cycle operand-load strobe for the datapath.
- iter_vld_o  out  1  datapath iterates this cycle.
- iter_end_o  out  1  last iteration this cycle; asserted together with iter_vld_o.
- iter_counter_o  out  CNT_W  index of the current iteration, 0-based.
- quot_bits_calculated_o  out  CNT_W  equals 4*(iter_counter_o+1)-1 while iter_vld_o is high, else 0.
- quot_discard_num_one_hot_o  out  4  bit k set means k LSBs are discarded; valid with iter_end_o and held through DONE.
- done_valid_o  out  1  result ready for post-process.
- done_ready_i  in  1  post-process accepts the result.
- done_special_o  out  1  the completed operation took the special path.

Behaviour:
- Reset values: all outputs 0 except start_ready_o=1. State=IDLE, registered fmt=F64, discard=4'b0001.
- States: IDLE, PRE, ITER, DONE.
- IDLE:
  - start_valid_i & special_i: go to DONE; set done_special_o=1, discard=4'b0001.
  - start_valid_i & !special_i: latch fmt_i; go to PRE.
- PRE: iter_start_o=1 for exactly one cycle; go to ITER. iter_counter_o=0.
- ITER:
  - iter_vld_o=1 every cycle; counter increments by 1 per cycle.
  - iter_end_o=1 when counter==N-1, where N comes from the latched format.
  - On iter_end_o: counter clears to 0 and state goes to DONE.
  - Discard one-hot is registered on the iter_end_o cycle: F64 4'b0010, F32 4'b0100, F16 4'b1000.
- DONE:
  - done_valid_o=1, held with stable done_special_o and discard until done_ready_i.
  - On accept: go to IDLE; clear done_special_o.
  - A start offered in that same cycle is not accepted (start_ready_o=0 in DONE).
- Latency, non-special: 1 cycle to leave IDLE + 1 PRE + N ITER. done_valid_o rises N+2 cycles after acceptance (F64 16, F32 9, F16 6).
- Special latency: done_valid_o one cycle after acceptance.
- kill_i:
  - In any state: next state IDLE, counter 0, done_valid_o deasserted next cycle, no iter_end_o issued.
  - kill_i beats start_valid_i in the same cycle.
- rst beats kill_i; reset mid-ITER aborts with no iter_end_o.
- Counter saturation cannot occur: N ≤ 14 < 2^CNT_W. An assertion checks counter < N in ITER.
- fmt_i is sampled only on acceptance; changes during an operation are ignored.

Decomposition:
- fdiv_pkg holds:
  - fmt enum (FMT_F16/F32/F64).
  - state enum.
  - per-format iteration-count and discard one-hot constants.
  - function iter_num(fmt).
- No sub-module; a single FSM plus counter is natural.

Test Plan:
- F64, start accepted at cycle 0 → iter_start_o at cycle 1; iter_vld_o cycles 2–15; iter_end_o at cycle 15 with counter=13, quot_bits=55, discard=4'b0010; done_valid_o at cycle 16.
- F32 and F16 back-to-back with done_ready_i=1 → iter_end_o at counter=6, quot_bits=27, discard=4'b0100. Then counter=3, quot_bits=15, discard=4'b1000. Second start_ready_o rises the cycle after the first accept.
- special_i=1 with F64 → no iter_start_o or iter_vld_o; done_valid_o next cycle, done_special_o=1, discard=4'b0001.
- done_ready_i low for 5 cycles in DONE → done_valid_o and discard stable; start_valid_i ignored; accept returns to IDLE.
- kill_i at ITER counter=7 (F64) → next cycle IDLE, counter=0, no iter_end_o, no done_valid_o. A following start behaves normally.
- rst asserted mid-ITER → next cycle all outputs at reset values, start_ready_o=1.
